apb_req_bridge: RTL and testbench

- Single-outstanding bridge from a simple req/gnt memory-style request port to an APB4 master port.
- Sits directly upstream of APB slaves such as the APB register file (apb_regs_intf); its APB outputs drive that block's slave interface.
- One transfer at a time; fixed SETUP/ACCESS sequencing; read data and slave error are returned on a one-cycle response pulse.

---
 rtl/apb_req_bridge.sv | 175 +++++++++++++++++
 tb/tb_apb_req_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_bridge.sv
// ============================================================================
// Module   : apb_req_bridge
// Purpose  : Single-outstanding req/gnt to APB4 master bridge; one-cycle
//            response pulse carries read data and slave error.
// Options  : APB_REQ_BRIDGE_TIMEOUT_EN adds an ACCESS-phase timeout that
//            completes a stuck transfer with rsp_err_o=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  // request side
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    gnt_o,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // APB master side
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Elaboration-time parameter sanity checks.
  if (ADDR_WIDTH < 3) begin : g_chk_addr
    $error("apb_req_bridge: ADDR_WIDTH must be >= 3");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_chk_data
    $error("apb_req_bridge: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("apb_req_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [2:0]              r_pprot;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]        r_cnt;
`endif

  // Grant is only possible while no transfer is in flight.
  assign gnt_o = (r_state == ST_IDLE) && req_i;

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state     <= ST_IDLE;
      r_paddr     <= '0;
      r_pprot     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      // Response fields are a single-cycle pulse and read as zero otherwise.
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_paddr   <= req_addr_i;
            r_pprot   <= req_prot_i;
            r_pwrite  <= req_we_i;
            r_pwdata  <= req_we_i ? req_wdata_i : '0;
            r_pstrb   <= req_we_i ? req_strb_i  : '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end

        ST_ACCESS: begin
          if (pready_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pslverr_i;
            r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_IDLE;
          end
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
          else begin
            if (r_cnt != C_CNT_MAX) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            // This stalled cycle is the last one allowed: abort with error.
            if (r_cnt == C_CNT_LAST) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_psel      <= 1'b0;
              r_penable   <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
`endif
        end

        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign paddr_o     = r_paddr;
  assign pprot_o     = r_pprot;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign pwdata_o    = r_pwdata;
  assign pstrb_o     = r_pstrb;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_bridge.sv
// ============================================================================
// Module   : tb_apb_req_bridge
// Purpose  : Directed self-checking bench for apb_req_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_bridge;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int TIMEOUT    = 4;

  logic                  pclk_i = 1'b0;
  logic                  preset_ni = 1'b0;
  logic                  req_i = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr_i = '0;
  logic                  req_we_i = 1'b0;
  logic [DATA_WIDTH-1:0] req_wdata_i = '0;
  logic [STRB_WIDTH-1:0] req_strb_i = '0;
  logic [2:0]            req_prot_i = '0;
  logic                  gnt_o;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i = 1'b0;
  logic [DATA_WIDTH-1:0] prdata_i = '0;
  logic                  pslverr_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  apb_req_bridge #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .pclk_i     (pclk_i),
    .preset_ni  (preset_ni),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .req_we_i   (req_we_i),
    .req_wdata_i(req_wdata_i),
    .req_strb_i (req_strb_i),
    .req_prot_i (req_prot_i),
    .gnt_o      (gnt_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .paddr_o    (paddr_o),
    .pprot_o    (pprot_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot);
    req_i       = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_prot_i  = prot;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #3;
    check_eq("rst_psel", psel_o, 0);
    check_eq("rst_penable", penable_o, 0);
    check_eq("rst_rsp_valid", rsp_valid_o, 0);
    check_eq("rst_paddr", paddr_o, 0);
    tick();
    tick();
    preset_ni = 1'b1;
    tick();
    check_eq("idle_gnt_noreq", gnt_o, 0);

    // ---------------- write, zero wait ----------------
    pready_i = 1'b1;
    drive_req(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'b010);
    #1;
    check_eq("wr_gnt_t0", gnt_o, 1);
    tick();
    req_i = 1'b0;
    #1;
    check_eq("wr_gnt_t1", gnt_o, 0);
    check_eq("wr_psel_t1", psel_o, 1);
    check_eq("wr_penable_t1", penable_o, 0);
    check_eq("wr_paddr", paddr_o, 32'h8);
    check_eq("wr_pwrite", pwrite_o, 1);
    check_eq("wr_pwdata", pwdata_o, 32'hDEADBEEF);
    check_eq("wr_pstrb", pstrb_o, 4'hF);
    check_eq("wr_pprot", pprot_o, 3'b010);
    check_eq("wr_rsp_t1", rsp_valid_o, 0);
    tick();
    check_eq("wr_psel_t2", psel_o, 1);
    check_eq("wr_penable_t2", penable_o, 1);
    check_eq("wr_rsp_t2", rsp_valid_o, 0);
    tick();
    check_eq("wr_rsp_t3", rsp_valid_o, 1);
    check_eq("wr_err_t3", rsp_err_o, 0);
    check_eq("wr_rdata_t3", rsp_rdata_o, 0);
    check_eq("wr_psel_t3", psel_o, 0);
    check_eq("wr_penable_t3", penable_o, 0);
    tick();
    check_eq("wr_rsp_t4", rsp_valid_o, 0);

    // ---------------- read, 3 wait states ----------------
    pready_i = 1'b0;
    prdata_i = 32'hBAD0BAD0;
    drive_req(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 3'b001);
    #1;
    check_eq("rd_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0;
    check_eq("rd_pwdata_zero", pwdata_o, 0);
    check_eq("rd_pstrb_setup", pstrb_o, 0);
    check_eq("rd_pwrite", pwrite_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rd_stall_psel", psel_o, 1);
      check_eq("rd_stall_penable", penable_o, 1);
      check_eq("rd_stall_paddr", paddr_o, 32'h10);
      check_eq("rd_stall_pstrb", pstrb_o, 0);
      check_eq("rd_stall_rsp", rsp_valid_o, 0);
    end
    tick();
    pready_i = 1'b1;
    prdata_i = 32'h12345678;
    check_eq("rd_ready_penable", penable_o, 1);
    tick();
    prdata_i = 32'hBAD0BAD0;
    pready_i = 1'b0;
    check_eq("rd_rsp_valid", rsp_valid_o, 1);
    check_eq("rd_rsp_rdata", rsp_rdata_o, 32'h12345678);
    check_eq("rd_rsp_err", rsp_err_o, 0);
    tick();
    check_eq("rd_rsp_drop", rsp_valid_o, 0);
    check_eq("rd_rdata_zero", rsp_rdata_o, 0);

    // ---------------- slave error ----------------
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    drive_req(1'b1, 32'h20, 32'h0000A5A5, 4'h3, 3'b000);
    #1;
    check_eq("err_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0;
    tick();
    tick();
    check_eq("err_rsp_valid", rsp_valid_o, 1);
    check_eq("err_rsp_err", rsp_err_o, 1);
    pslverr_i = 1'b0;
    drive_req(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
    #1;
    check_eq("err_next_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0;
    check_eq("err_rsp_drop", rsp_err_o, 0);
    tick();
    tick();
    tick();

    // ---------------- back-to-back, 4 transfers ----------------
    pready_i = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      req_i      = (i <= 9);
      req_we_i   = 1'b1;
      req_addr_i = 32'(i * 4);
      #1;
      check_eq("b2b_gnt", gnt_o, ((i % 3) == 0) && (i <= 9));
      check_eq("b2b_rsp", rsp_valid_o, ((i % 3) == 0) && (i > 0));
      check_eq("b2b_psel", psel_o, (i % 3) != 0);
      if ((i % 3) == 1) check_eq("b2b_paddr", paddr_o, 32'((i - 1) * 4));
      tick();
    end
    req_i = 1'b0;

    // ---------------- reset mid-ACCESS ----------------
    pready_i = 1'b0;
    drive_req(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
    tick();
    req_i = 1'b0;
    tick();
    check_eq("rst_mid_penable", penable_o, 1);
    #2;
    preset_ni = 1'b0;
    #1;
    check_eq("rst_async_psel", psel_o, 0);
    check_eq("rst_async_penable", penable_o, 0);
    check_eq("rst_async_rsp", rsp_valid_o, 0);
    tick();
    pready_i  = 1'b1;
    preset_ni = 1'b1;
    tick();
    check_eq("rst_after_rsp", rsp_valid_o, 0);
    check_eq("rst_after_psel", psel_o, 0);
    tick();
    check_eq("rst_after_rsp2", rsp_valid_o, 0);
    drive_req(1'b1, 32'h34, 32'h1, 4'h1, 3'b000);
    #1;
    check_eq("rst_after_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0;
    tick();
    tick();
    check_eq("rst_after_done", rsp_valid_o, 1);
    tick();

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    // ---------------- timeout ----------------
    pready_i = 1'b0;
    prdata_i = 32'hCAFEF00D;
    drive_req(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    tick();
    req_i = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check_eq("to_access_penable", penable_o, 1);
      check_eq("to_access_rsp", rsp_valid_o, 0);
    end
    tick();
    check_eq("to_psel", psel_o, 0);
    check_eq("to_rsp_valid", rsp_valid_o, 1);
    check_eq("to_rsp_err", rsp_err_o, 1);
    check_eq("to_rsp_rdata", rsp_rdata_o, 0);
    pready_i = 1'b1;
    tick();
    check_eq("to_late_rsp", rsp_valid_o, 0);
    check_eq("to_late_psel", psel_o, 0);
    tick();
    check_eq("to_late_rsp2", rsp_valid_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
